// File: rtl/ebr_rd_stream_if.sv
// Bundle of the command, EBR read-port and output-stream signals for ebr_rd_stream.
// The slave modport is the streamer; the master modport is whatever drives and sinks it.
interface ebr_rd_stream_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;

  logic [AW-1:0] ebr_rd_addr;
  logic          ebr_rd_ena;
  logic [DW-1:0] ebr_rd_data;

  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  cmd_addr, cmd_len, cmd_valid, ebr_rd_data, out_ready,
    output cmd_ready, ebr_rd_addr, ebr_rd_ena, out_data, out_last, out_valid
  );

  modport master (
    output cmd_addr, cmd_len, cmd_valid, ebr_rd_data, out_ready,
    input  cmd_ready, ebr_rd_addr, ebr_rd_ena, out_data, out_last, out_valid
  );
endinterface

// File: rtl/ebr_rd_stream.sv
// Turns an (address, length) burst command into a sequence of EBR reads and streams the
// returned words out through a 2-entry registered buffer with valid/ready and last marking.
module ebr_rd_stream #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input logic             clk,
  input logic             rst,
  ebr_rd_stream_if.slave  bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] next_addr_q, next_addr_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic          last0_q, last0_d, last1_q, last1_d;

  logic          pop;
  logic          rd_ena;
  logic [2:0]    pending;
  logic [1:0]    occ_after_pop;

  always_comb begin
    pop           = (occ_q != 2'd0) && bus.out_ready;
    // Words that will hold a buffer slot next cycle if no read is issued now
    pending       = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    rd_ena        = (state_q == StRun) && (pending < 3'd2);
    occ_after_pop = occ_q - 2'(pop);
  end

  always_comb begin
    state_d         = state_q;
    next_addr_d     = next_addr_q;
    last_addr_d     = last_addr_q;
    rem_d           = rem_q;
    inflight_d      = rd_ena;
    inflight_last_d = rd_ena && (rem_q == '0);
    occ_d           = occ_q + 2'(inflight_q) - 2'(pop);
    data0_d         = data0_q;
    data1_d         = data1_q;
    last0_d         = last0_q;
    last1_d         = last1_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          state_d     = StRun;
          next_addr_d = bus.cmd_addr;
          rem_d       = bus.cmd_len;
        end
      end
      StRun: begin
        if (rd_ena && (rem_q == '0)) state_d = StDrain;
      end
      StDrain: begin
        if (pop && last0_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rd_ena) begin
      last_addr_d = next_addr_q;
      next_addr_d = next_addr_q + AW'(1);
      rem_d       = rem_q - AW'(1);
    end

    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end

    // Returning read data always lands in the first slot left free after this cycle's pop
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        data0_d = bus.ebr_rd_data;
        last0_d = inflight_last_q;
      end else begin
        data1_d = bus.ebr_rd_data;
        last1_d = inflight_last_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      next_addr_q     <= '0;
      last_addr_q     <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      data0_q         <= '0;
      data1_q         <= '0;
      last0_q         <= 1'b0;
      last1_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      next_addr_q     <= next_addr_d;
      last_addr_q     <= last_addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      data0_q         <= data0_d;
      data1_q         <= data1_d;
      last0_q         <= last0_d;
      last1_q         <= last1_d;
    end
  end

  always_comb begin
    bus.cmd_ready   = (state_q == StIdle);
    bus.ebr_rd_ena  = rd_ena;
    bus.ebr_rd_addr = rd_ena ? next_addr_q : last_addr_q;
    bus.out_valid   = (occ_q != 2'd0);
    bus.out_data    = data0_q;
    bus.out_last    = last0_q && (occ_q != 2'd0);
  end

endmodule
